// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes, FSM encoding, flag layout.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MUL   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bit positions inside the packed NZCV flag vector.
  localparam int FLAG_V    = 0;
  localparam int FLAG_C    = 1;
  localparam int FLAG_Z    = 2;
  localparam int FLAG_N    = 3;
  localparam int NUM_FLAGS = 4;

endpackage

// File: rtl/alu_multicycle_if.sv
// Request/response bundle between the control FSM (master) and the ALU (slave).
interface alu_multicycle_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             z_flag;
  logic             n_flag;
  logic             c_flag;
  logic             v_flag;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a, b,
    input  result, z_flag, n_flag, c_flag, v_flag, busy, done
  );

  modport slave (
    input  start, op, a, b,
    output result, z_flag, n_flag, c_flag, v_flag, busy, done
  );
endinterface

// File: rtl/alu_shift_mul_unit.sv
// Serial datapath: one-bit shift or one shift-add multiply step per cycle.
// The step outputs are the values the registers take on the next step, so the
// caller can capture the final result on the same edge as the last step.
module alu_shift_mul_unit #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             is_mul,
  input  logic             shl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [CNTW-1:0]  count_init,
  output logic [WIDTH-1:0] step_result,
  output logic             step_carry,
  output logic             last_step
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] mplr;
  logic [CNTW-1:0]  count;
  logic             mode_mul;
  logic             mode_shl;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] shift_next;

  // Next-step values for both datapath modes.
  always_comb begin
    acc_next    = mplr[0] ? (acc + opnd) : acc;
    shift_next  = mode_shl ? {opnd[WIDTH-2:0], 1'b0} : {1'b0, opnd[WIDTH-1:1]};
    step_result = mode_mul ? acc_next : shift_next;
    step_carry  = mode_mul ? 1'b0 : (mode_shl ? opnd[WIDTH-1] : opnd[0]);
    last_step   = (count == CNTW'(1));
  end

  // Operand load on accept, then one step per cycle with a down-counting step budget.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      opnd     <= '0;
      mplr     <= '0;
      count    <= '0;
      mode_mul <= 1'b0;
      mode_shl <= 1'b0;
    end else if (load) begin
      acc      <= '0;
      opnd     <= a;
      mplr     <= b;
      count    <= count_init;
      mode_mul <= is_mul;
      mode_shl <= shl;
    end else if (step) begin
      count <= count - CNTW'(1);
      if (mode_mul) begin
        acc  <= acc_next;
        opnd <= {opnd[WIDTH-2:0], 1'b0};
        mplr <= {1'b0, mplr[WIDTH-1:1]};
      end else begin
        opnd <= shift_next;
      end
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Registered multi-cycle ALU with start/busy/done handshake and NZCV flags.
//
//   state | meaning
//   IDLE  | waiting for start; single-cycle ops and shift-by-0 finish here
//   SHIFT | serial shift, one bit per cycle
//   MUL   | shift-add multiply, one multiplier bit per cycle
//   DONE  | done pulse; result and flags were loaded on entry
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic       Clock,
  input logic       Resetn,
  alu_multicycle_if.slave bus
);

  localparam int SHW  = $clog2(WIDTH);
  localparam int CNTW = SHW + 1;

  state_t                 state;
  logic [WIDTH-1:0]       result_q;
  logic [NUM_FLAGS-1:0]   flags_q;
  logic                   busy_q;
  logic                   done_q;

  logic [SHW-1:0]         shamt;
  logic                   is_shift;
  logic                   serial_op;
  logic                   unit_load;
  logic                   unit_step;
  logic [CNTW-1:0]        count_init;
  logic [WIDTH-1:0]       step_result;
  logic                   step_carry;
  logic                   last_step;

  logic [WIDTH:0]         sum;
  logic [WIDTH:0]         diff;
  logic [WIDTH-1:0]       fast_res;
  logic                   fast_c;
  logic                   fast_v;

  function automatic logic [NUM_FLAGS-1:0] pack_flags(input logic [WIDTH-1:0] r,
                                                      input logic c, input logic v);
    logic [NUM_FLAGS-1:0] f;
    f         = '0;
    f[FLAG_N] = r[WIDTH-1];
    f[FLAG_Z] = (r == '0);
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

  assign shamt      = bus.b[SHW-1:0];
  assign is_shift   = (bus.op == OP_SLL) || (bus.op == OP_SRL);
  assign serial_op  = (bus.op == OP_MUL) || (is_shift && (shamt != '0));
  assign unit_load  = (state == IDLE) && bus.start && serial_op;
  assign unit_step  = (state == SHIFT) || (state == MUL);
  assign count_init = (bus.op == OP_MUL) ? CNTW'(WIDTH) : {1'b0, shamt};

  // Single-cycle results; the default arm covers shift by 0, which passes a through.
  always_comb begin
    sum      = {1'b0, bus.a} + {1'b0, bus.b};
    diff     = {1'b0, bus.a} - {1'b0, bus.b};
    fast_res = bus.a;
    fast_c   = 1'b0;
    fast_v   = 1'b0;
    case (bus.op)
      OP_ADD: begin
        fast_res = sum[WIDTH-1:0];
        fast_c   = sum[WIDTH];
        fast_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        fast_res = diff[WIDTH-1:0];
        fast_c   = diff[WIDTH];
        fast_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND:  fast_res = bus.a & bus.b;
      OP_OR:   fast_res = bus.a | bus.b;
      OP_XOR:  fast_res = bus.a ^ bus.b;
      default: fast_res = bus.a;
    endcase
  end

  alu_shift_mul_unit #(
    .WIDTH (WIDTH),
    .CNTW  (CNTW)
  ) u_shift_mul (
    .clk         (Clock),
    .rst_n       (Resetn),
    .load        (unit_load),
    .step        (unit_step),
    .is_mul      (bus.op == OP_MUL),
    .shl         (bus.op == OP_SLL),
    .a           (bus.a),
    .b           (bus.b),
    .count_init  (count_init),
    .step_result (step_result),
    .step_carry  (step_carry),
    .last_step   (last_step)
  );

  // Control FSM plus result/flag registers, which load only on entry to DONE.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state    <= IDLE;
      result_q <= '0;
      flags_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (serial_op) begin
              state  <= (bus.op == OP_MUL) ? MUL : SHIFT;
              busy_q <= 1'b1;
            end else begin
              state    <= DONE;
              done_q   <= 1'b1;
              result_q <= fast_res;
              flags_q  <= pack_flags(fast_res, fast_c, fast_v);
            end
          end
        end
        SHIFT, MUL: begin
          if (last_step) begin
            state    <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= step_result;
            flags_q  <= pack_flags(step_result, step_carry, 1'b0);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.n_flag = flags_q[FLAG_N];
  assign bus.z_flag = flags_q[FLAG_Z];
  assign bus.c_flag = flags_q[FLAG_C];
  assign bus.v_flag = flags_q[FLAG_V];
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle at WIDTH=16 and WIDTH=8.
module tb_alu_multicycle;
  import alu_pkg::*;

  logic Clock = 1'b0;
  logic Resetn = 1'b0;
  always #5 Clock = ~Clock;

  alu_multicycle_if #(.WIDTH(16)) bus16 ();
  alu_multicycle_if #(.WIDTH(8))  bus8 ();

  alu_multicycle #(.WIDTH(16)) dut16 (.Clock(Clock), .Resetn(Resetn), .bus(bus16));
  alu_multicycle #(.WIDTH(8))  dut8  (.Clock(Clock), .Resetn(Resetn), .bus(bus8));

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flags;   // {n,z,c,v}
    int          lat;
    int          issue;
  } exp_t;

  exp_t q16[$];
  exp_t q8[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] res, input logic [3:0] flags, input int lat);
    exp_t e;
    e.res = res; e.flags = flags; e.lat = lat; e.issue = 0;
    return e;
  endfunction

  // Reference: plain integer arithmetic on the operation's definition.
  function automatic exp_t ref_model(input int w, input int op,
                                     input longint unsigned a, input longint unsigned b);
    exp_t e;
    longint unsigned mask, half, r;
    longint sa, sb, s, lim;
    int n, shw;
    logic c, v;
    mask = (64'd1 << w) - 1;
    half = 64'd1 << (w - 1);
    lim  = longint'(half);
    shw  = 0;
    while ((1 << shw) < w) shw++;
    n  = int'(b & ((64'd1 << shw) - 1));
    sa = (a >= half) ? longint'(a) - longint'(mask) - 1 : longint'(a);
    sb = (b >= half) ? longint'(b) - longint'(mask) - 1 : longint'(b);
    c = 1'b0; v = 1'b0; e.lat = 1; r = 0;
    case (op)
      0: begin r = a + b; c = (r > mask); s = sa + sb; v = (s >= lim) || (s < -lim); end
      1: begin r = a - b; c = (a < b);    s = sa - sb; v = (s >= lim) || (s < -lim); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = a << n; c = (n > 0) && (((a >> (w - n)) & 1) != 0); e.lat = n + 1; end
      6: begin r = a >> n; c = (n > 0) && (((a >> (n - 1)) & 1) != 0); e.lat = n + 1; end
      default: begin r = a * b; e.lat = w + 1; end
    endcase
    r = r & mask;
    e.res   = 16'(r);
    e.flags = {((r >> (w - 1)) & 1) != 0, r == 0, c, v};
    e.issue = 0;
    return e;
  endfunction

  // Monitor, 16-bit DUT: busy every cycle, and result/flags/latency on every done.
  always @(negedge Clock) begin
    int k;
    logic exp_busy;
    exp_t e;
    if (Resetn) begin
      exp_busy = 1'b0;
      if (q16.size() > 0) begin
        k = cyc - q16[0].issue;
        exp_busy = (k >= 1) && (k < q16[0].lat);
      end
      chk("busy16", 64'(bus16.busy), 64'(exp_busy));
      if (bus16.done) begin
        if (q16.size() == 0) begin
          checks++; fails++;
          $display("FAIL done16: done=1 with no operation outstanding (t=%0t)", $time);
        end else begin
          e = q16.pop_front();
          chk("latency16", 64'(cyc - e.issue), 64'(e.lat));
          chk("result16", 64'(bus16.result), 64'(e.res));
          chk("nzcv16", 64'({bus16.n_flag, bus16.z_flag, bus16.c_flag, bus16.v_flag}), 64'(e.flags));
        end
      end
    end
  end

  // Monitor, 8-bit DUT.
  always @(negedge Clock) begin
    int k;
    logic exp_busy;
    exp_t e;
    if (Resetn) begin
      exp_busy = 1'b0;
      if (q8.size() > 0) begin
        k = cyc - q8[0].issue;
        exp_busy = (k >= 1) && (k < q8[0].lat);
      end
      chk("busy8", 64'(bus8.busy), 64'(exp_busy));
      if (bus8.done) begin
        if (q8.size() == 0) begin
          checks++; fails++;
          $display("FAIL done8: done=1 with no operation outstanding (t=%0t)", $time);
        end else begin
          e = q8.pop_front();
          chk("latency8", 64'(cyc - e.issue), 64'(e.lat));
          chk("result8", 64'(bus8.result), 64'(e.res));
          chk("nzcv8", 64'({bus8.n_flag, bus8.z_flag, bus8.c_flag, bus8.v_flag}), 64'(e.flags));
        end
      end
    end
  end

  // Issue one request; hold2 keeps start high into the DONE cycle, where it must be ignored.
  task automatic issue(input bit w8, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input exp_t e, input bit hold2);
    @(negedge Clock);
    e.issue = cyc;
    if (w8) begin
      bus8.op = op; bus8.a = a[7:0]; bus8.b = b[7:0]; bus8.start = 1'b1;
      q8.push_back(e);
    end else begin
      bus16.op = op; bus16.a = a; bus16.b = b; bus16.start = 1'b1;
      q16.push_back(e);
    end
    @(posedge Clock);
    if (hold2) @(posedge Clock);
    #1;
    bus16.start = 1'b0;
    bus8.start  = 1'b0;
    // Operands must already be captured.
    bus16.a = 16'($urandom); bus16.b = 16'($urandom); bus16.op = 3'($urandom);
    bus8.a  = 8'($urandom);  bus8.b  = 8'($urandom);  bus8.op  = 3'($urandom);
  endtask

  task automatic wait_idle(input bit w8);
    int t;
    t = 0;
    while (((w8 ? q8.size() : q16.size()) > 0) && t < 200) begin
      @(negedge Clock);
      t++;
    end
    if ((w8 ? q8.size() : q16.size()) > 0) begin
      checks++; fails++;
      $display("FAIL timeout%s: no done within 200 cycles", w8 ? "8" : "16");
      q8.delete();
      q16.delete();
    end
    @(negedge Clock);
  endtask

  task automatic run_one(input bit w8, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input exp_t e);
    issue(w8, op, a, b, e, 1'b0);
    wait_idle(w8);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [15:0] ra, rb;
    bus16.start = 1'b0; bus16.op = 3'd0; bus16.a = '0; bus16.b = '0;
    bus8.start  = 1'b0; bus8.op  = 3'd0; bus8.a  = '0; bus8.b  = '0;
    #12;
    chk("reset_result", 64'(bus16.result), 64'd0);
    chk("reset_nzcv", 64'({bus16.n_flag, bus16.z_flag, bus16.c_flag, bus16.v_flag}), 64'd0);
    chk("reset_busy", 64'(bus16.busy), 64'd0);
    chk("reset_done", 64'(bus16.done), 64'd0);
    @(negedge Clock);
    Resetn = 1'b1;

    run_one(0, OP_ADD, 16'h7FFF, 16'h0001, mk(16'h8000, 4'b1001, 1));
    run_one(0, OP_SUB, 16'h0005, 16'h0005, mk(16'h0000, 4'b0100, 1));
    run_one(0, OP_SUB, 16'h0003, 16'h0005, mk(16'hFFFE, 4'b1010, 1));

    // SLL by 4 with stray start pulses while busy.
    issue(0, OP_SLL, 16'h1001, 16'h0004, mk(16'h0010, 4'b0010, 5), 1'b0);
    @(negedge Clock); bus16.start = 1'b1;
    @(negedge Clock); bus16.start = 1'b0;
    @(negedge Clock); bus16.start = 1'b1;
    @(negedge Clock); bus16.start = 1'b0;
    wait_idle(0);

    run_one(0, OP_MUL, 16'd300, 16'd300, mk(16'h5F90, 4'b0000, 17));
    run_one(0, OP_AND, 16'h00F0, 16'h0F0F, mk(16'h0000, 4'b0100, 1));
    run_one(0, OP_SRL, 16'hABCD, 16'h0010, mk(16'hABCD, 4'b1000, 1));

    // start held into the DONE cycle must not launch a second operation.
    issue(0, OP_ADD, 16'h0001, 16'h0001, mk(16'h0002, 4'b0000, 1), 1'b1);
    wait_idle(0);
    run_one(0, OP_SUB, 16'h0003, 16'h0005, mk(16'hFFFE, 4'b1010, 1));

    // Reset in the middle of a multiply.
    issue(0, OP_MUL, 16'h1234, 16'h5678, ref_model(16, 7, 64'h1234, 64'h5678), 1'b0);
    repeat (7) @(posedge Clock);
    #1 Resetn = 1'b0;
    #1;
    chk("midreset_result", 64'(bus16.result), 64'd0);
    chk("midreset_nzcv", 64'({bus16.n_flag, bus16.z_flag, bus16.c_flag, bus16.v_flag}), 64'd0);
    chk("midreset_busy", 64'(bus16.busy), 64'd0);
    chk("midreset_done", 64'(bus16.done), 64'd0);
    q16.delete();
    @(negedge Clock);
    @(negedge Clock);
    Resetn = 1'b1;
    repeat (25) @(negedge Clock);
    run_one(0, OP_ADD, 16'd2, 16'd3, mk(16'h0005, 4'b0000, 1));

    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      case ($urandom_range(0, 5))
        0: ra = 16'h7FFF;
        1: ra = 16'h8000;
        2: rb = ra;
        3: rb = 16'hFFFF;
        default: ;
      endcase
      run_one(0, rop, ra, rb, ref_model(16, int'(rop), 64'(ra), 64'(rb)));
    end

    run_one(1, OP_SRL, 16'h0081, 16'h0007, mk(16'h0001, 4'b0000, 8));
    for (int i = 0; i < 20; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = 16'($urandom_range(0, 255));
      rb  = 16'($urandom_range(0, 255));
      run_one(1, rop, ra, rb, ref_model(8, int'(rop), 64'(ra), 64'(rb)));
    end

    repeat (3) @(negedge Clock);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised, registered successor of the processor's combinational ALU.
- Adds bitwise AND/OR/XOR (true bitwise, not logical), serial shifts and shift-add multiply.
- Provides a start/busy/done handshake toward the control FSM and a full NZCV flag set.
- Sits between the A register / BusWires and the G register. The control FSM waits on done before capturing result.

Parameters:
- WIDTH, 16, operand/result width in bits (>=4).
- SHW, $clog2(WIDTH), width of the shift-amount field taken from b[SHW-1:0]. This is a localparam, derived from WIDTH, and is never overridden.

Ports:
- Clock  input  1  system clock, rising edge.
- Resetn  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request, sampled on the rising edge while idle.
- op  input  3  operation code (see Behaviour).
- a  input  WIDTH  first operand (A register).
- b  input  WIDTH  second operand (BusWires); for shifts, b[SHW-1:0] is the shift amount.
- result  output  WIDTH  registered result, held until the next completion.
- z_flag  output  1  result == 0.
- n_flag  output  1  result[WIDTH-1].
- c_flag  output  1  carry / borrow / last bit shifted out.
- v_flag  output  1  signed overflow.
- busy  output  1  high while a multi-cycle op is in progress.
- done  output  1  one-cycle pulse; result and flags are valid from this cycle on.

Behaviour:
- Reset: Clock and a single asynchronous active-low reset (Resetn) are fixed. While Resetn=0: result=0, all flags=0, busy=0, done=0, FSM in IDLE. Reset mid-operation aborts the operation; no done is issued.
- Op codes:
  - 000 ADD
  - 001 SUB (a-b)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLL
  - 110 SRL (logical)
  - 111 MUL (low WIDTH bits of the unsigned product)
- Operand capture: a, b and op are latched on the edge where start=1 in IDLE. Later changes to the inputs do not affect the operation in flight.
- FSM states:
  - IDLE: on start with ADD..XOR, or with a shift by 0, compute in one step, go to DONE.
  - IDLE: on start with SLL/SRL by n>0, load count=n, go to SHIFT.
  - IDLE: on start with MUL, load count=WIDTH, go to MUL.
  - SHIFT: shift by one bit per cycle and decrement count. When count reaches 1, go to DONE.
  - MUL: one shift-add step per cycle (multiplier LSB first). When count reaches 1, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Latency (start edge to done high): single-cycle ops and shift-by-0 = 1 cycle; shift by n = n+1 cycles; MUL = WIDTH+1 cycles.
- busy: high in SHIFT and MUL only. A start while not in IDLE (including DONE) is ignored.
- Output update: result and flags update only on entry to DONE. Between operations they hold their last values.
- Arithmetic is modulo 2^WIDTH.
- Flag rules:
  - ADD: c = carry out; v = (a_sign == b_sign) && (r_sign != a_sign).
  - SUB: c = borrow (1 when a < b unsigned); v = (a_sign != b_sign) && (r_sign != a_sign).
  - AND/OR/XOR: c = v = 0.
  - SLL/SRL: c = last bit shifted out (0 for shift by 0); v = 0.
  - MUL: c = v = 0.
  - All ops: z and n are derived from the final result.
- Shift amount uses b[SHW-1:0] only; upper bits of b are ignored.
- A start asserted in the same cycle as done is ignored, because the FSM is in DONE, not IDLE.

Decomposition:
- Package alu_pkg holds:
  - op-code constants OP_ADD..OP_MUL;
  - the state encoding IDLE/SHIFT/MUL/DONE;
  - the flag index constants.
- One sub-module, alu_shift_mul_unit, holds the per-cycle SLL/SRL/shift-add datapath: accumulator, shifting operand, count register and last-out bit. The top level keeps the FSM, the single-cycle ops, the flag logic and the output registers.

Test Plan:
- ADD a=16'h7FFF, b=16'h0001 -> one cycle later done=1, result=16'h8000, n=1, v=1, c=0, z=0, busy never high.
- SUB a=16'h0005, b=16'h0005 -> result=0, z=1, c=0, v=0; then SUB a=3, b=5 -> result=16'hFFFE, c=1, n=1.
- SLL a=16'h1001, b=4 -> busy for 4 cycles, done at cycle 5, result=16'h0010, c=1; start pulses during busy are ignored and produce no extra done.
- MUL a=300, b=300 -> done at cycle 17, result=16'h5F90, c=v=0; AND a=16'h00F0, b=16'h0F0F -> result=0, z=1.
- Reset: assert Resetn=0 mid-MUL (cycle 8) -> result, flags, busy and done are 0 immediately, no done after release; a fresh ADD 2+3 then gives result=5.
- Parameter check: WIDTH=8, SRL a=8'h81, b=7 -> done at cycle 8, result=8'h01, c=0.
